// File: rtl/timer_pkg.sv
// Register-map constants and control-register layout shared by the timer array and its channels.
package timer_pkg;

    localparam int OFF_CNT = 0;
    localparam int OFF_LIM = 4;
    localparam int OFF_CTL = 8;

    localparam int CTL_READY   = 0;
    localparam int CTL_OVERRUN = 1;
    localparam int CTL_IE      = 2;
    localparam int CTL_ONESHOT = 3;
    localparam int CTL_EN      = 4;
    localparam int CTL_W       = 5;

    // Field order matches the CTL bit indices above, MSB first.
    typedef struct packed {
        logic en;
        logic oneshot;
        logic ie;
        logic overrun;
        logic ready;
    } ctl_t;

    localparam ctl_t CTL_RST = 5'b10000;

endpackage

// File: rtl/timer_chan.sv
// One interval-timer channel: counter, limit and control/status flags.
module timer_chan
    import timer_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            TICK,
    input  logic            wr_cnt,
    input  logic            wr_lim,
    input  logic            wr_ctl,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] cnt,
    output logic [BITS-1:0] lim,
    output ctl_t            ctl,
    output logic            irq
);

    logic [BITS-1:0] cnt_d;
    logic [BITS-1:0] lim_d;
    ctl_t            ctl_d;
    logic            term;
    logic            fire;

    assign term = TICK && ctl.en && (lim != '0) && (cnt == lim - 1'b1);
    // A CNT or LIM write swallows the tick, including its event.
    assign fire = term && !wr_cnt && !wr_lim;
    assign irq  = ctl.ready && ctl.ie;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        cnt_d = cnt;
        lim_d = lim;
        ctl_d = ctl;

        if (wr_cnt) begin
            cnt_d         = wdata;
            ctl_d.ready   = 1'b0;
            ctl_d.overrun = 1'b0;
        end else if (wr_lim) begin
            lim_d = wdata;
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = '0;
        end else if (TICK && ctl.en) begin
            cnt_d = cnt + 1'b1;
        end

        if (wr_ctl) begin
            ctl_d.ie      = wdata[CTL_IE];
            ctl_d.oneshot = wdata[CTL_ONESHOT];
            ctl_d.en      = wdata[CTL_EN];
            if (!wdata[CTL_READY])   ctl_d.ready   = 1'b0;
            if (!wdata[CTL_OVERRUN]) ctl_d.overrun = 1'b0;
        end

        // Applied after the software clear so a same-cycle hardware set wins.
        if (fire) begin
            if (ctl.ready) ctl_d.overrun = 1'b1;
            else           ctl_d.ready   = 1'b1;
            if (ctl.oneshot && !wr_ctl) ctl_d.en = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
            lim <= '0;
            ctl <= CTL_RST;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt <= cnt_d;
            lim <= lim_d;
            ctl <= ctl_d;
        end
    end

endmodule

// File: rtl/timer_array.sv
// Memory-mapped multi-channel interval timer: shared prescaler, address decode,
// tri-state read-back and combined interrupt.
module timer_array
    import timer_pkg::*;
#(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] BASE     = 32'hFFFFF100,
    parameter int              NCHAN    = 4,
    parameter int              STRIDE   = 16,
    parameter int              PRESCALE = 60000000
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    output logic            INTR,
    output logic            TICK
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   pre;
    logic            pre_last;
    logic [BITS-1:0] cnt_a [NCHAN];
    logic [BITS-1:0] lim_a [NCHAN];
    ctl_t            ctl_a [NCHAN];
    logic [NCHAN-1:0] irq_v;
    logic [NCHAN-1:0] wr_cnt_v;
    logic [NCHAN-1:0] wr_lim_v;
    logic [NCHAN-1:0] wr_ctl_v;
    logic [BITS-1:0] rdata;
    logic            rsel;

    function automatic logic [BITS-1:0] reg_addr(input int ch, input int off);
        return BASE + BITS'(ch * STRIDE + off);
    endfunction

    assign pre_last = (pre == PRE_LAST);
    // Gated by reset so TICK is quiet while held, even when PRESCALE is 1.
    assign TICK     = RESET_N && pre_last;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)      pre <= '0;
        else if (pre_last) pre <= '0;
        else               pre <= pre + 1'b1;
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        assign wr_cnt_v[i] = WE && (ABUS == reg_addr(i, OFF_CNT));
        assign wr_lim_v[i] = WE && (ABUS == reg_addr(i, OFF_LIM));
        assign wr_ctl_v[i] = WE && (ABUS == reg_addr(i, OFF_CTL));

        timer_chan #(.BITS(BITS)) u_chan (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .TICK    (TICK),
            .wr_cnt  (wr_cnt_v[i]),
            .wr_lim  (wr_lim_v[i]),
            .wr_ctl  (wr_ctl_v[i]),
            .wdata   (DBUS),
            .cnt     (cnt_a[i]),
            .lim     (lim_a[i]),
            .ctl     (ctl_a[i]),
            .irq     (irq_v[i])
        );
    end

    always_comb begin
        rdata = '0;
        rsel  = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (ABUS == reg_addr(i, OFF_CNT)) begin
                rdata = cnt_a[i];
                rsel  = 1'b1;
            end
            if (ABUS == reg_addr(i, OFF_LIM)) begin
                rdata = lim_a[i];
                rsel  = 1'b1;
            end
            if (ABUS == reg_addr(i, OFF_CTL)) begin
                rdata = BITS'(ctl_a[i]);
                rsel  = 1'b1;
            end
        end
        if (ABUS == reg_addr(NCHAN, 0)) begin
            rdata = BITS'(irq_v);
            rsel  = 1'b1;
        end
    end

    assign DBUS = (rsel && !WE) ? rdata : 'z;
    assign INTR = |irq_v;

endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array: directed literal checks plus randomized bus traffic
// compared every cycle against a behavioural register-level model.
module tb_timer_array;

    localparam int          BITS     = 32;
    localparam int          NCHAN    = 2;
    localparam int          STRIDE   = 16;
    localparam int          PRESCALE = 1;
    localparam logic [31:0] BASE     = 32'hFFFFF100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] abus  = '0;
    logic        we    = 1'b0;
    logic        drv   = 1'b0;
    logic [31:0] wd    = '0;
    logic        chk_en = 1'b0;
    wire  [31:0] dbus;
    wire         intr;
    wire         tick;

    int n_tests = 0;
    int n_fail  = 0;

    assign dbus = drv ? wd : 'z;
    for (genvar b = 0; b < 32; b++) begin : g_pu
        pullup (dbus[b]);
    end

    always #5 clk = ~clk;

    timer_array #(
        .BITS(BITS), .BASE(BASE), .NCHAN(NCHAN), .STRIDE(STRIDE), .PRESCALE(PRESCALE)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ABUS(abus), .DBUS(dbus), .WE(we), .INTR(intr), .TICK(tick)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_cnt [NCHAN];
    logic [31:0] m_lim [NCHAN];
    logic        m_rdy [NCHAN];
    logic        m_ovr [NCHAN];
    logic        m_ie  [NCHAN];
    logic        m_os  [NCHAN];
    logic        m_en  [NCHAN];
    int          m_pre;

    function automatic logic [31:0] addr_of(input int ch, input int off);
        return BASE + 32'(ch * STRIDE + off);
    endfunction

    function automatic logic [31:0] m_ctl(input int c);
        return {27'b0, m_en[c], m_os[c], m_ie[c], m_ovr[c], m_rdy[c]};
    endfunction

    function automatic logic [31:0] m_stat();
        logic [31:0] s = '0;
        for (int c = 0; c < NCHAN; c++) s[c] = m_rdy[c] & m_ie[c];
        return s;
    endfunction

    task automatic m_read(input logic [31:0] a, output logic hit, output logic [31:0] v);
        hit = 1'b0;
        v   = '1;
        for (int c = 0; c < NCHAN; c++) begin
            if (a == addr_of(c, 0)) begin hit = 1'b1; v = m_cnt[c]; end
            if (a == addr_of(c, 4)) begin hit = 1'b1; v = m_lim[c]; end
            if (a == addr_of(c, 8)) begin hit = 1'b1; v = m_ctl(c); end
        end
        if (a == addr_of(NCHAN, 0)) begin hit = 1'b1; v = m_stat(); end
    endtask

    logic tk, wc, wl, wt, fire, rdy0, os0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0;
            for (int c = 0; c < NCHAN; c++) begin
                m_cnt[c] = '0; m_lim[c] = '0; m_rdy[c] = 1'b0; m_ovr[c] = 1'b0;
                m_ie[c] = 1'b0; m_os[c] = 1'b0; m_en[c] = 1'b1;
            end
        end else begin
            tk    = (m_pre == PRESCALE - 1);
            m_pre = tk ? 0 : m_pre + 1;
            for (int c = 0; c < NCHAN; c++) begin
                wc   = we && (abus == addr_of(c, 0));
                wl   = we && (abus == addr_of(c, 4));
                wt   = we && (abus == addr_of(c, 8));
                fire = tk && m_en[c] && (m_lim[c] != 0) && (m_cnt[c] == m_lim[c] - 32'd1) && !wc && !wl;
                rdy0 = m_rdy[c];
                os0  = m_os[c];
                if (wc) begin
                    m_cnt[c] = wd; m_rdy[c] = 1'b0; m_ovr[c] = 1'b0;
                end else if (wl) begin
                    m_lim[c] = wd; m_cnt[c] = '0;
                end else if (fire) begin
                    m_cnt[c] = '0;
                end else if (tk && m_en[c]) begin
                    m_cnt[c] = m_cnt[c] + 32'd1;
                end
                if (wt) begin
                    m_ie[c] = wd[2]; m_os[c] = wd[3]; m_en[c] = wd[4];
                    if (!wd[0]) m_rdy[c] = 1'b0;
                    if (!wd[1]) m_ovr[c] = 1'b0;
                end
                if (fire) begin
                    if (rdy0) m_ovr[c] = 1'b1;
                    else      m_rdy[c] = 1'b1;
                    if (os0 && !wt) m_en[c] = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic        c_hit;
    logic [31:0] c_val;
    always @(negedge clk) begin
        if (chk_en) begin
            check("intr", 32'(intr), 32'(m_stat() != 0));
            check("tick", 32'(tick), 32'(rst_n && (m_pre == PRESCALE - 1)));
            if (!we) begin
                m_read(abus, c_hit, c_val);
                check("dbus_read", dbus, c_val);
            end
        end
    end

    // ---------------- stimulus helpers (called just after a rising edge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus = a; wd = d; we = 1'b1; drv = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; drv = 1'b0; abus = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        abus = a;
        #2;
        check(name, dbus, exp);
    endtask

    localparam logic [31:0] CNT0 = BASE + 32'h00, LIM0 = BASE + 32'h04, CTL0 = BASE + 32'h08;
    localparam logic [31:0] CNT1 = BASE + 32'h10, LIM1 = BASE + 32'h14, CTL1 = BASE + 32'h18;
    localparam logic [31:0] STAT = BASE + 32'h20;

    int          r, ch, kind;
    logic [31:0] d;

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;

        // Reset state
        rd_chk("rst_cnt0", CNT0, 32'h0);
        rd_chk("rst_lim0", LIM0, 32'h0);
        rd_chk("rst_ctl0", CTL0, 32'h10);
        rd_chk("rst_stat", STAT, 32'h0);
        check("rst_intr", 32'(intr), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        abus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("tick_run", 32'(tick), 32'h1);

        // Periodic mode, channel 0
        wr(LIM0, 32'd3);     rd_chk("per_cnt_a", CNT0, 32'd0);
        wr(CTL0, 32'h14);    rd_chk("per_cnt_b", CNT0, 32'd1);
        step();              rd_chk("per_cnt_c", CNT0, 32'd2);
        check("per_intr_lo", 32'(intr), 32'h0);
        step();              rd_chk("per_cnt_d", CNT0, 32'd0);
        rd_chk("per_ctl_ready", CTL0, 32'h15);
        rd_chk("per_stat", STAT, 32'h1);
        check("per_intr_hi", 32'(intr), 32'h1);
        wr(CTL0, 32'h14);    rd_chk("per_ctl_clr", CTL0, 32'h14);
        check("per_intr_drop", 32'(intr), 32'h0);

        // Overrun, channel 0
        wr(LIM0, 32'd2);     rd_chk("ovr_cnt_a", CNT0, 32'd0);
        step();              rd_chk("ovr_cnt_b", CNT0, 32'd1);
        step();              rd_chk("ovr_cnt_c", CNT0, 32'd0);
        rd_chk("ovr_ctl_rdy", CTL0, 32'h15);
        step();              rd_chk("ovr_cnt_d", CNT0, 32'd1);
        step();              rd_chk("ovr_cnt_e", CNT0, 32'd0);
        rd_chk("ovr_ctl_ovr", CTL0, 32'h17);
        wr(CTL0, 32'h14);    rd_chk("ovr_ctl_clr", CTL0, 32'h14);

        // One-shot, channel 1
        wr(LIM1, 32'd5);
        wr(CTL1, 32'h1C);    rd_chk("os_cnt_a", CNT1, 32'd1);
        repeat (4) step();
        rd_chk("os_ctl_done", CTL1, 32'h0D);
        repeat (3) step();
        rd_chk("os_cnt_hold", CNT1, 32'd0);

        // Clear on the term cycle: the hardware set wins
        wr(CTL1, 32'h14);    rd_chk("sim_ctl_a", CTL1, 32'h14);
        wr(LIM1, 32'd3);
        step();
        step();              rd_chk("sim_cnt_pre", CNT1, 32'd2);
        wr(CTL1, 32'h14);    rd_chk("sim_rdy_kept", CTL1, 32'h15);
        // CNT write on a tick cycle
        wr(CNT1, 32'h10);    rd_chk("sim_cnt_wr", CNT1, 32'h10);
        rd_chk("sim_cnt_wr_flags", CTL1, 32'h14);
        // Free-run wrap with LIM=0
        wr(LIM1, 32'd0);
        wr(CNT1, 32'hFFFF_FFFE);
        step();              rd_chk("wrap_a", CNT1, 32'hFFFF_FFFF);
        step();              rd_chk("wrap_b", CNT1, 32'h0);
        rd_chk("wrap_no_rdy", CTL1, 32'h14);

        // Unmapped read leaves the bus to the pull-up
        rd_chk("unmapped", BASE + 32'h0C, 32'hFFFF_FFFF);

        // Asynchronous reset mid-count
        wr(LIM0, 32'd0);
        wr(CNT0, 32'd100);   rd_chk("arst_pre", CNT0, 32'd100);
        #1 rst_n = 1'b0;
        #1;
        rd_chk("arst_cnt0", CNT0, 32'h0);
        rd_chk("arst_lim1", LIM1, 32'h0);
        rd_chk("arst_ctl0", CTL0, 32'h10);
        rd_chk("arst_ctl1", CTL1, 32'h10);
        rd_chk("arst_stat", STAT, 32'h0);
        check("arst_intr", 32'(intr), 32'h0);
        abus = '0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // Randomized traffic checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99);
            ch = $urandom_range(0, NCHAN - 1);
            if (r < 30) begin
                kind = $urandom_range(0, 2);
                case (kind)
                    0: d = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : 32'($urandom_range(0, 7));
                    1: d = 32'($urandom_range(0, 6));
                    default: begin
                        d = $urandom;
                        d[4] = ($urandom_range(0, 3) != 0);
                    end
                endcase
                wr(addr_of(ch, kind * 4), d);
            end else begin
                if (r < 85)      abus = addr_of(ch, 4 * $urandom_range(0, 2));
                else if (r < 92) abus = STAT;
                else             abus = BASE + 32'($urandom_range(0, 63));
                step();
            end
        end
        abus = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
- Memory-mapped multi-channel interval timer on the processor data bus (ABUS/DBUS/WE).
- Parametrised successor of the single-channel timer: NCHAN independent channels, each with its own CNT/LIM/CTL registers.
- A shared prescaler generates the count tick.
- Adds per-channel interrupt enable, a one-shot/periodic mode, a run enable, a global status register and a combined INTR output.

Parameters:
- BITS, 32, data/address bus width and counter width.
- BASE, 32'hFFFFF100, byte address of channel 0 CNT.
- NCHAN, 4, number of channels (1..8).
- STRIDE, 16, byte spacing between channel register blocks.
- PRESCALE, 60000000, CLK cycles per tick (>=1; 1 = tick every cycle).

Ports:
- CLK, input, 1, system clock.
- RESET_N, input, 1, asynchronous active-low reset.
- ABUS, input, BITS, byte address from the memory stage.
- DBUS, inout, BITS, write data in when WE; read data driven when selected and !WE, else high-Z.
- WE, input, 1, write strobe (one-cycle write).
- INTR, output, 1, OR over channels of (ready & IE).
- TICK, output, 1, prescaler tick pulse, for debug.

Behaviour:
- Register map, channel i, with A = BASE + i*STRIDE:
  - A+0 CNT.
  - A+4 LIM.
  - A+8 CTL: bit0 READY, bit1 OVERRUN, bit2 IE, bit3 ONESHOT, bit4 EN; other bits read 0.
- STAT at BASE + NCHAN*STRIDE: read-only; bit i = READY_i & IE_i; upper bits 0.
- Unmapped addresses: DBUS not driven; writes ignored.
- Reset (RESET_N=0, async) values:
  - CNT = 0, LIM = 0, READY = 0, OVERRUN = 0, IE = 0, ONESHOT = 0, EN = 1. EN=1 preserves legacy free-run behaviour.
  - Prescaler = 0; TICK = 0; INTR = 0.
- Prescaler: counts 0..PRESCALE-1 and wraps. TICK=1 for exactly one CLK in the cycle where the count == PRESCALE-1.
- Terminal condition per channel: term = TICK & EN & (LIM != 0) & (CNT == LIM-1).
- Count update per channel, evaluated in this priority order each CLK:
  1. Write CNT: CNT <= DBUS; READY <= 0; OVERRUN <= 0; the tick is ignored this cycle.
  2. Write LIM: LIM <= DBUS; CNT <= 0; the tick is ignored this cycle.
  3. term: CNT <= 0. If ONESHOT, EN <= 0.
  4. Otherwise, TICK & EN: CNT <= CNT+1, modulo 2^BITS. With LIM == 0 the counter free-runs and wraps with no event.
- CTL write:
  - IE, ONESHOT and EN load from DBUS[2], DBUS[3], DBUS[4].
  - READY and OVERRUN are write-0-to-clear: a 0 clears the bit, a 1 leaves it unchanged.
- Event flags on term, judged against the pre-cycle READY:
  - If READY was 1: OVERRUN <= 1.
  - Else: READY <= 1.
  - A hardware set beats a software clear of the same bit in the same cycle.
  - A one-shot term in the same cycle as a CTL write with EN=1 leaves EN = 1 (the software write wins for EN).
- Reads are combinational in the same cycle as the address; no read side effects.
- INTR is combinational from the registered flags. It asserts the cycle after READY sets (with IE=1) and deasserts the cycle after the clear write.
- Mid-operation reset clears all state asynchronously. Counting resumes from a prescaler count of 0 after the RESET_N release.

Decomposition:
- Shared package timer_pkg holds:
  - Offsets OFF_CNT=0, OFF_LIM=4, OFF_CTL=8.
  - CTL bit indices CTL_READY..CTL_EN.
  - CTL reset value 5'b10000.
- Sub-module timer_chan (one channel):
  - Inputs: CLK, RESET_N, TICK, wr_cnt, wr_lim, wr_ctl, wdata.
  - Outputs: cnt, lim, ctl, irq.
- The top holds the prescaler, address decode, read mux, the DBUS tri-state driver and the STAT/INTR reduction. Channels are instantiated with a generate loop.

Test Plan:
All tests use PRESCALE=1 and NCHAN=2.
1. Reset check: hold RESET_N=0 then release. Expect:
   - Reads return CNT0=0, LIM0=0, CTL0=0x10, STAT=0.
   - INTR=0.
2. Periodic mode, channel 0: write LIM0=3, CTL0=0x14. Expect:
   - CNT0 sequence 0,1,2,0.
   - READY sets 3 ticks after the write.
   - INTR=1 one cycle later.
   - STAT=0x1.
   - Writing CTL0=0x14 with bit0=0 clears READY, and INTR drops the next cycle.
3. Overrun: LIM0=2, no clear. Expect READY=1 after 2 ticks, OVERRUN=1 after 4 ticks, CNT0 wraps 0,1,0,1.
4. One-shot mode, channel 1: write LIM1=5, CTL1=0x1C. Expect:
   - READY1=1 and EN1 reads 0 after 5 ticks.
   - CNT1 stays 0 thereafter.
   - Channel 0 is unaffected.
5. Simultaneous events:
   - CTL clear on the term cycle: READY stays 1.
   - CNT write of 0x10 on a tick cycle: CNT=0x10, READY=OVERRUN=0.
   - LIM=0: free-run from 0xFFFFFFFE wraps to 0 with no READY.
6. Bus: read an unmapped address, e.g. BASE+0xC. Expect DBUS high-Z. Assert RESET_N low mid-count. Expect all registers return to reset values immediately, without waiting for CLK.
